conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming 3x3 window generator directly upstream of the convolution array.
- Accepts one RGB pixel (3 channels x 8 bit) per handshake, raster order.
- Keeps two line buffers plus a 3x3 pixel shift window.
- Emits the 27-byte 3x3x3 patch that feeds the 216-bit array input, with valid padding and stride 1.

Parameters:
- IMG_W, 16, image width in pixels (>=3).
- IMG_H, 16, image height in pixels (>=3).
- CNT_W, 16, width of the column and row counters (must hold IMG_W-1 and IMG_H-1).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pix_valid  input  1  input pixel valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- pix_sof  input  1  start of frame, qualified by the pixel handshake; this pixel is (x=0, y=0).
- pix_data  input  24  channel ch in bits [8ch+7:8ch], ch=0..2.
- win_valid  output  1  window register holds a valid patch.
- win_ready  input  1  downstream accepts the patch.
- win_data  output  216  3x3x3 patch, 27 bytes (packing below).
- win_last  output  1  patch is the final window of the frame.

Behaviour:
- Reset (async, rst_n=0):
  - win_valid=0, win_last=0, win_data=0.
  - Column and row counters = 0.
  - pix_ready=1 once rst_n=1.
  - Line buffer and shift window contents are not cleared; they are don't-care until refilled.
- Accept: acc = pix_valid && pix_ready. With no acc, no state changes except the output drain.
- pix_ready = !win_valid || win_ready (single-entry output register; combinational from win_ready).
- Position of the accepted pixel (x,y):
  - If pix_sof=1, it is (0,0).
  - Otherwise it is the current counters.
  - After acc: x wraps from IMG_W-1 to 0 and increments y; y wraps from IMG_H-1 to 0.
- Line buffers:
  - lb1 holds row y-1; lb0 holds row y-2.
  - On acc at column x: read lb1[x] and lb0[x] first, then write lb0[x]<=old lb1[x] and lb1[x]<=pix_data.
  - No read/write hazard: read-before-write at the same address in the same cycle.
- Shift window: on acc, each of the 3 rows shifts left one column.
  - New right column (top to bottom) = {lb0[x] read, lb1[x] read, pix_data}.
- Emit condition: acc with x>=2 and y>=2.
  - Next cycle: win_valid=1 and win_data = window covering rows y-2..y, cols x-2..x.
  - win_last=1 if x==IMG_W-1 and y==IMG_H-1, else 0.
- Latency: 1 cycle from the accepting edge of the bottom-right pixel to win_valid.
- Packing: byte index k = (r*3+c)*3+ch; win_data[8k+7:8k].
  - r=0 is the top row (y-2), c=0 is the left column (x-2), ch as in pix_data.
- Output hold: while win_valid && !win_ready, win_data and win_last are stable and pix_ready=0.
- Drain: win_valid && win_ready with no new emit clears win_valid next cycle.
  - Drain plus emit in the same cycle: win_valid stays 1 and the new patch is loaded, with no bubble.
- Output size: windows per frame = (IMG_W-2)*(IMG_H-2). Columns 0..1 and rows 0..1 never emit.
- Row seam: windows are never emitted at x<2, so pixels from the previous row left in the shift window are never exposed.
- pix_sof mid-frame: counters resync; that pixel is treated as (0,0).
  - The first emit of the new frame comes at (2,2) of the new frame.
  - A pending output window is unaffected.
- Reset mid-frame: the pending window is discarded and counting restarts at (0,0).

Test Plan:
- Basic frame: IMG_W=IMG_H=4, win_ready=1; pixel (x,y) has all channels = 16y+x; pix_sof on the first pixel.
  - Exactly 4 windows.
  - First window one cycle after (2,2) is accepted; its byte k(r,c,ch) = 16r+c, so byte0=0x00 and byte26=0x22.
  - Last window: byte0=0x11, byte26=0x33, win_last=1; win_last=0 on the other three.
- Backpressure: same frame with win_ready=0 from the first window.
  - pix_ready drops the cycle after win_valid rises; win_data stays stable for 10 cycles.
  - Releasing win_ready resumes the stream with no lost or duplicated windows; still 4 windows.
- Back-to-back: continuous pix_valid and win_ready=1, IMG_W=IMG_H=5.
  - 9 windows; win_valid stays high across consecutive emits in a row (no bubbles).
  - Window at (4,4) has byte26=0x44.
- Gaps: random pix_valid deassertion (50%), IMG_W=IMG_H=4.
  - Window sequence and contents identical to the basic test.
- Resync: send 6 pixels, then assert pix_sof and send a full 4x4 frame.
  - Exactly 4 windows, contents as in the basic test.
- Async reset mid-frame: assert rst_n=0 between clock edges after 11 pixels.
  - win_valid=0 immediately.
  - A following full frame yields exactly 4 correct windows.

Source files
------------

// File: rtl/conv_window_gen.sv
// Streaming 3x3x3 window generator feeding the convolution array.
// Takes one RGB pixel per handshake in raster order, keeps two line buffers
// and a 3x3 shift window, and emits valid-padded stride-1 patches through a
// single-entry output register.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int CNT_W = 16
) (
    input  logic           clk_i,
    input  logic           rst_n,
    input  logic           pix_valid,
    output logic           pix_ready,
    input  logic           pix_sof,
    input  logic [23:0]    pix_data,
    output logic           win_valid,
    input  logic           win_ready,
    output logic [215:0]   win_data,
    output logic           win_last
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // lb1 holds row y-1, lb0 holds row y-2
    logic [23:0]      lb0 [IMG_W];
    logic [23:0]      lb1 [IMG_W];
    // shift window, [row][col], row 0 = top, col 0 = left
    logic [23:0]      win [3][3];
    logic [23:0]      new_col [3];

    logic [CNT_W-1:0] col_cnt;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] cur_x;
    logic [CNT_W-1:0] cur_y;
    logic [AW-1:0]    lb_addr;
    logic             acc;
    logic             emit;
    logic             emit_last;
    logic [215:0]     next_data;

    assign pix_ready = !win_valid || win_ready;
    assign acc       = pix_valid && pix_ready;

    // a start-of-frame pixel is always (0,0), regardless of the counters
    assign cur_x   = pix_sof ? '0 : col_cnt;
    assign cur_y   = pix_sof ? '0 : row_cnt;
    assign lb_addr = cur_x[AW-1:0];

    assign emit      = acc && (cur_x >= CNT_W'(2)) && (cur_y >= CNT_W'(2));
    assign emit_last = (cur_x == CNT_W'(IMG_W - 1)) && (cur_y == CNT_W'(IMG_H - 1));

    // incoming right column: line buffers are read before this cycle's write
    always_comb begin
        new_col[0] = lb0[lb_addr];
        new_col[1] = lb1[lb_addr];
        new_col[2] = pix_data;
    end

    // patch as it will look after this cycle's shift, packed pixel by pixel
    always_comb begin
        next_data = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            next_data[(r*3+0)*24 +: 24] = win[r][1];
            next_data[(r*3+1)*24 +: 24] = win[r][2];
            next_data[(r*3+2)*24 +: 24] = new_col[r];
        end
    end

    // line buffer update: old row y-1 moves down to y-2, new pixel becomes y-1
    always_ff @(posedge clk_i) begin
        if (acc) begin
            lb0[lb_addr] <= lb1[lb_addr];
            lb1[lb_addr] <= pix_data;
        end
    end

    // shift each window row left and load the new right column
    always_ff @(posedge clk_i) begin
        if (acc) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= new_col[r];
            end
        end
    end

    // raster position counters, wrapping at the frame edges
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (acc) begin
            if (cur_x == CNT_W'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (cur_y == CNT_W'(IMG_H - 1)) ? '0 : cur_y + CNT_W'(1);
            end else begin
                col_cnt <= cur_x + CNT_W'(1);
                row_cnt <= cur_y;
            end
        end
    end

    // single-entry output register; drain and reload can happen together
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_data  <= '0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_last  <= emit_last;
            win_data  <= next_data;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
